imm_field_encoder: RTL and testbench



---
 rtl/imm_pkg.sv | 70 +++++++
 rtl/imm_range_check.sv | 33 +++
 rtl/imm_field_encoder.sv | 136 +++++++++++++
 tb/tb_imm_field_encoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the RV32I immediate encoder and the
// decode-stage tests: format enum, per-format bit masks, pack and re-extend helpers.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  // Instruction bits owned by the immediate for each format; zero for illegal codes
  // so that an illegal format leaves the base word untouched.
  function automatic logic [31:0] imm_mask(input logic [2:0] src);
    logic [31:0] m;
    case (src)
      IMM_I:   m = 32'hFFF0_0000;
      IMM_S:   m = 32'hFE00_0F80;
      IMM_B:   m = 32'hFE00_0F80;
      IMM_U:   m = 32'hFFFF_F000;
      IMM_J:   m = 32'hFFFF_F000;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  // Scatter the immediate into its instruction bit positions (upper bits truncated).
  function automatic logic [31:0] imm_pack(input logic [2:0] src, input logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    case (src)
      IMM_I: w[31:20] = imm[11:0];
      IMM_S: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      IMM_B: begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      IMM_U: w[31:12] = imm[31:12];
      IMM_J: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  // Decode-side view: rebuild the sign-extended immediate from an instruction word.
  function automatic logic [31:0] imm_extend(input logic [2:0] src, input logic [31:0] instr);
    logic [31:0] e;
    case (src)
      IMM_I:   e = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   e = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   e = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   e = {instr[31:12], 12'h000};
      IMM_J:   e = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational representability check: flags immediates that do not fit the
// selected format, odd branch/jump offsets, and illegal format codes.
module imm_range_check
  import imm_pkg::*;
(
  input  logic [2:0]  imm_src_i,
  input  logic [31:0] imm_i,
  output logic        imm_err_o
);

  logic sext12_ok;
  logic sext13_ok;
  logic sext21_ok;

  // A field fits when every bit above its sign bit equals the sign bit.
  assign sext12_ok = (&imm_i[31:11]) || !(|imm_i[31:11]);
  assign sext13_ok = (&imm_i[31:12]) || !(|imm_i[31:12]);
  assign sext21_ok = (&imm_i[31:20]) || !(|imm_i[31:20]);

  // Select the rule for the requested format; unknown formats are always errors.
  always_comb begin
    imm_err_o = 1'b1;
    case (imm_src_i)
      IMM_I:   imm_err_o = !sext12_ok;
      IMM_S:   imm_err_o = !sext12_ok;
      IMM_B:   imm_err_o = !sext13_ok || imm_i[0];
      IMM_U:   imm_err_o = |imm_i[11:0];
      IMM_J:   imm_err_o = !sext21_ok || imm_i[0];
      default: imm_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_field_encoder.sv
// Two-stage valid/ready immediate encoder: S1 packs the immediate into the base
// word and flags range errors, S2 is the output register. Counts output
// handshakes (wrapping) and erroneous ones (saturating).
// Optional build macro IMM_ROUNDTRIP_CHK_EN adds a RtMismatch output that
// re-extends the emitted word and compares it with the original immediate.
module imm_field_encoder
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       ImmSrc,
  input  logic [31:0]      Imm,
  input  logic [31:0]      BaseInstr,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [31:0]      InstrOut,
  output logic             ImmErr,
  output logic [CNT_W-1:0] EncCount,
  output logic [CNT_W-1:0] ErrCount
`ifdef IMM_ROUNDTRIP_CHK_EN
  ,
  output logic             RtMismatch
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_instr_q;
  logic             s1_err_q;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_instr_q;
  logic             s2_err_q;
  logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        in_fire;
  logic        out_fire;
  logic        s2_load;
  logic        s1_err_d;
  logic [31:0] s1_instr_d;

  assign InReady  = !s1_valid_q || !s2_valid_q || OutReady;
  assign in_fire  = InValid && InReady;
  assign out_fire = s2_valid_q && OutReady;
  // S1 moves forward whenever S2 is empty or is draining this cycle.
  assign s2_load  = s1_valid_q && (!s2_valid_q || OutReady);

  imm_range_check u_range_check (
    .imm_src_i (ImmSrc),
    .imm_i     (Imm),
    .imm_err_o (s1_err_d)
  );

  // Illegal formats have an all-zero mask and pack, so the base passes through.
  assign s1_instr_d = (BaseInstr & ~imm_mask(ImmSrc)) | imm_pack(ImmSrc, Imm);

  // Stage occupancy and statistics counters next-state.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    enc_cnt_d  = enc_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (in_fire)       s1_valid_d = 1'b1;
    else if (s2_load)  s1_valid_d = 1'b0;
    if (s2_load)       s2_valid_d = 1'b1;
    else if (out_fire) s2_valid_d = 1'b0;
    if (out_fire) begin
      enc_cnt_d = enc_cnt_q + CNT_W'(1);
      if (s2_err_q && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline and counter registers; reset drops any in-flight words.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      enc_cnt_q  <= enc_cnt_d;
      err_cnt_q  <= err_cnt_d;
      if (in_fire) begin
        s1_instr_q <= s1_instr_d;
        s1_err_q   <= s1_err_d;
      end
      if (s2_load) begin
        s2_instr_q <= s1_instr_q;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  assign OutValid = s2_valid_q;
  assign InstrOut = s2_instr_q;
  assign ImmErr   = s2_err_q;
  assign EncCount = enc_cnt_q;
  assign ErrCount = err_cnt_q;

`ifdef IMM_ROUNDTRIP_CHK_EN
  logic [2:0]  s1_src_q, s2_src_q;
  logic [31:0] s1_imm_q, s2_imm_q;

  // Carry the original format and immediate alongside the word for the compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_src_q <= '0;
      s1_imm_q <= '0;
      s2_src_q <= '0;
      s2_imm_q <= '0;
    end else begin
      if (in_fire) begin
        s1_src_q <= ImmSrc;
        s1_imm_q <= Imm;
      end
      if (s2_load) begin
        s2_src_q <= s1_src_q;
        s2_imm_q <= s1_imm_q;
      end
    end
  end

  // Only meaningful for words that encoded cleanly.
  assign RtMismatch = s2_valid_q && !s2_err_q && (imm_extend(s2_src_q, s2_instr_q) != s2_imm_q);
`endif

endmodule

// File: tb/tb_imm_field_encoder.sv
// Table-driven bench for imm_field_encoder with a queue scoreboard, plus
// latency, backpressure and mid-stream reset sequences.
module tb_imm_field_encoder;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  localparam int NVEC = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [2:0]  ImmSrc = 3'd0;
  logic [31:0] Imm = 32'd0;
  logic [31:0] BaseInstr = 32'd0;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic [31:0] InstrOut;
  logic        ImmErr;
  logic [15:0] EncCount;
  logic [15:0] ErrCount;

  vec_t vecs [NVEC];
  exp_t sb [$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   exp_enc = 0;
  int   exp_errc = 0;
  int   out_num = 0;
  bit   accepted = 1'b0;
  bit   hold_pending = 1'b0;
  logic [31:0] hold_instr = '0;
  logic        hold_err = 1'b0;

  imm_field_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .InValid   (InValid),
    .InReady   (InReady),
    .ImmSrc    (ImmSrc),
    .Imm       (Imm),
    .BaseInstr (BaseInstr),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .InstrOut  (InstrOut),
    .ImmErr    (ImmErr),
    .EncCount  (EncCount),
    .ErrCount  (ErrCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic set_inputs(input int idx);
    ImmSrc    = vecs[idx].src;
    Imm       = vecs[idx].imm;
    BaseInstr = vecs[idx].base;
    cur.instr = vecs[idx].exp_instr;
    cur.err   = vecs[idx].exp_err;
    InValid   = 1'b1;
  endtask

  // Called just after a falling edge with inputs set: evaluates the handshakes
  // that the next rising edge will perform, then advances to the next falling edge.
  task automatic tick();
    exp_t e;
    #1;
    accepted = 1'b0;
    if (!reset) begin
      if (hold_pending) begin
        check("hold_valid", 32'(OutValid), 32'd1);
        check("hold_instr", InstrOut, hold_instr);
        check("hold_err", 32'(ImmErr), 32'(hold_err));
      end
      if (OutValid && OutReady) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got instr=0x%08h, expected no output", InstrOut);
        end else begin
          e = sb.pop_front();
          $display("out %0d: instr=0x%08h err=%0d (expected 0x%08h err=%0d)",
                   out_num, InstrOut, ImmErr, e.instr, e.err);
          out_num++;
          check("instr_out", InstrOut, e.instr);
          check("imm_err", 32'(ImmErr), 32'(e.err));
          exp_enc++;
          if (e.err && exp_errc != 65535) exp_errc++;
        end
      end
      if (InValid && InReady) begin
        sb.push_back(cur);
        accepted = 1'b1;
      end
      hold_pending = OutValid && !OutReady;
      hold_instr   = InstrOut;
      hold_err     = ImmErr;
    end else begin
      hold_pending = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drive_vec(input int idx, input bit rnd_ready);
    set_inputs(idx);
    for (int t = 0; t < 20; t++) begin
      if (rnd_ready) OutReady = ($urandom_range(0, 3) != 0);
      tick();
      if (accepted) break;
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL accept_timeout vec=%0d: got no accept, expected accept", idx);
    end
    InValid = 1'b0;
  endtask

  task automatic drain();
    InValid  = 1'b0;
    OutReady = 1'b1;
    for (int t = 0; t < 20 && sb.size() != 0; t++) tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    InValid = 1'b0;
    tick();
    reset    = 1'b0;
    sb.delete();
    exp_enc  = 0;
    exp_errc = 0;
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0};
    vecs[1]  = '{3'd1, 32'h0000_0008, 32'h0020_A023, 32'h0020_A423, 1'b0};
    vecs[2]  = '{3'd3, 32'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0};
    vecs[4]  = '{3'd4, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0};
    vecs[5]  = '{3'd0, 32'h0000_0800, 32'h0000_0093, 32'h8000_0093, 1'b1};
    vecs[6]  = '{3'd2, 32'h0000_1001, 32'h0000_0063, 32'h8000_0063, 1'b1};
    vecs[7]  = '{3'd7, 32'h0000_0055, 32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[8]  = '{3'd0, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0};
    vecs[9]  = '{3'd1, 32'hFFFF_F800, 32'h0020_A023, 32'h8020_A023, 1'b0};
    vecs[10] = '{3'd3, 32'h1234_5001, 32'h0000_02B7, 32'h1234_52B7, 1'b1};
    vecs[11] = '{3'd4, 32'h0010_0000, 32'h0000_00EF, 32'h8000_00EF, 1'b1};
    vecs[12] = '{3'd4, 32'hFFFF_FFFE, 32'h0000_00EF, 32'hFFFF_F0EF, 1'b0};
    vecs[13] = '{3'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h000F_FFFF, 1'b0};
    vecs[14] = '{3'd2, 32'h0000_0000, 32'hFFFF_FFFF, 32'h01FF_F07F, 1'b0};
    vecs[15] = '{3'd5, 32'h0000_0000, 32'h0000_0033, 32'h0000_0033, 1'b1};
    vecs[16] = '{3'd2, 32'h0000_0002, 32'h0000_0063, 32'h0000_0163, 1'b0};
    vecs[17] = '{3'd1, 32'h0000_001F, 32'h0000_0000, 32'h0000_0F80, 1'b0};
    vecs[18] = '{3'd1, 32'hFFFF_F7FF, 32'h0000_0000, 32'h7E00_0F80, 1'b1};
    vecs[19] = '{3'd4, 32'h0000_0001, 32'h0000_00EF, 32'h0000_00EF, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_outvalid", 32'(OutValid), 32'd0);
    check("rst_instrout", InstrOut, 32'd0);
    check("rst_immerr", 32'(ImmErr), 32'd0);
    check("rst_enccount", 32'(EncCount), 32'd0);
    check("rst_errcount", 32'(ErrCount), 32'd0);
    check("rst_inready", 32'(InReady), 32'd1);
    @(negedge clk);

    // Two-cycle latency on a single word.
    OutReady = 1'b1;
    set_inputs(0);
    tick();
    check("lat_accept", 32'(accepted), 32'd1);
    InValid = 1'b0;
    #1;
    check("lat_cycle1_outvalid", 32'(OutValid), 32'd0);
    tick();
    #1;
    check("lat_cycle2_outvalid", 32'(OutValid), 32'd1);
    tick();

    // Stream the rest of the table under random backpressure.
    for (int i = 1; i < NVEC; i++) drive_vec(i, 1'b1);
    drain();
    check("stream_enccount", 32'(EncCount), 32'(exp_enc));
    check("stream_errcount", 32'(ErrCount), 32'(exp_errc));

    // Backpressure: three back-to-back words, OutReady low for four cycles.
    do_reset();
    OutReady = 1'b0;
    set_inputs(5);
    tick();
    check("bp_accept0", 32'(accepted), 32'd1);
    set_inputs(1);
    tick();
    check("bp_accept1", 32'(accepted), 32'd1);
    set_inputs(2);
    tick();
    check("bp_blocked_c2", 32'(accepted), 32'd0);
    tick();
    check("bp_blocked_c3", 32'(accepted), 32'd0);
    OutReady = 1'b1;
    tick();
    check("bp_accept2", 32'(accepted), 32'd1);
    drain();
    check("bp_enccount", 32'(EncCount), 32'd3);
    check("bp_errcount", 32'(ErrCount), 32'd1);

    // Reset with both stages full.
    OutReady = 1'b0;
    set_inputs(0);
    tick();
    check("mr_accept0", 32'(accepted), 32'd1);
    set_inputs(3);
    tick();
    check("mr_accept1", 32'(accepted), 32'd1);
    do_reset();
    #1;
    check("mr_outvalid", 32'(OutValid), 32'd0);
    check("mr_enccount", 32'(EncCount), 32'd0);
    check("mr_errcount", 32'(ErrCount), 32'd0);
    check("mr_inready", 32'(InReady), 32'd1);
    check("mr_instrout", InstrOut, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
